vec_reduce_engine: RTL and testbench

//   Parametrised array-reduction engine for HLS kernels. Streams elements 0..n-1 from two

---
 rtl/vec_reduce_engine.sv | 127 ++++++++++++
 tb/tb_vec_reduce_engine.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/vec_reduce_engine.sv
// Array-reduction engine: streams a[0..n-1] (and b) from read memories and reduces them
// to one scalar via sum(a), sum(a+b), dot(a,b) or signed max(a), with start/idle/done control.
module vec_reduce_engine #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned MEM_LAT = 1
) (
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   input  logic              start,
   input  logic [1:0]        mode,
   input  logic [ADDR_W-1:0] n,
   output logic              idle,
   output logic              done,
   output logic [DATA_W-1:0] return_val,
   output logic [ADDR_W-1:0] a_address0,
   output logic              a_ce0,
   input  logic [DATA_W-1:0] a_q0,
   output logic [ADDR_W-1:0] b_address0,
   output logic              b_ce0,
   input  logic [DATA_W-1:0] b_q0
);

   typedef enum logic [1:0] {StIdle, StFetch, StDrain, StFin} state_e;

   localparam logic [DATA_W-1:0] MinVal = {1'b1, {(DATA_W-1){1'b0}}};

   state_e              state_q, state_d;
   logic [1:0]          mode_q, mode_d;
   logic [ADDR_W-1:0]   n_q, n_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   acc_q, acc_d;
   logic [DATA_W-1:0]   ret_q, ret_d;
   logic [MEM_LAT-1:0]  vld_q, vld_d, vld_shift;
   logic [DATA_W-1:0]   sum_ab, prod_ab;
   logic                issue, beat;

   assign sum_ab  = a_q0 + b_q0;
   assign prod_ab = a_q0 * b_q0;
   assign beat    = vld_q[MEM_LAT-1];

   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      n_d       = n_q;
      addr_d    = addr_q;
      acc_d     = acc_q;
      ret_d     = ret_q;
      issue     = 1'b0;
      idle      = 1'b0;
      done      = 1'b0;
      vld_shift = MEM_LAT'(vld_q << 1);

      // Returning beats only exist while FETCH/DRAIN are active.
      if (beat) begin
         unique case (mode_q)
            2'b00: acc_d = acc_q + a_q0;
            2'b01: acc_d = acc_q + sum_ab;
            2'b10: acc_d = acc_q + prod_ab;
            default: acc_d = ($signed(a_q0) > $signed(acc_q)) ? a_q0 : acc_q;
         endcase
      end

      unique case (state_q)
         StIdle: begin
            idle = 1'b1;
            if (start) begin
               mode_d = mode;
               n_d    = n;
               addr_d = '0;
               acc_d  = (mode == 2'b11) ? MinVal : '0;
               if (n == '0) begin
                  state_d = StFin;
                  ret_d   = '0;
               end else begin
                  state_d = StFetch;
               end
            end
         end
         StFetch: begin
            issue = 1'b1;
            if (addr_q == n_q - 1'b1) state_d = StDrain;
            else                      addr_d  = addr_q + 1'b1;
         end
         StDrain: begin
            // Current beat is the last one when nothing remains behind it.
            if (vld_shift == '0) begin
               state_d = StFin;
               ret_d   = acc_d;
            end
         end
         default: begin
            done    = 1'b1;
            state_d = StIdle;
         end
      endcase

      vld_d = vld_shift | MEM_LAT'(issue);
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q <= StIdle;
         mode_q  <= '0;
         n_q     <= '0;
         addr_q  <= '0;
         acc_q   <= '0;
         ret_q   <= '0;
         vld_q   <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         n_q     <= n_d;
         addr_q  <= addr_d;
         acc_q   <= acc_d;
         ret_q   <= ret_d;
         vld_q   <= vld_d;
      end
   end

   assign return_val = ret_q;
   assign a_address0 = addr_q;
   assign b_address0 = addr_q;
   assign a_ce0      = issue;
   assign b_ce0      = issue & ((mode_q == 2'b01) || (mode_q == 2'b10));

endmodule

// File: tb/tb_vec_reduce_engine.sv
// Scoreboard bench: dut1 (32-bit, latency 1) and dut2 (8-bit, latency 3) with directed runs.
module tb_vec_reduce_engine;

   logic sys_clk = 1'b0;
   logic sys_rst_n = 1'b0;
   always #5 sys_clk = ~sys_clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   always @(posedge sys_clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] val;
      int          lat;
   } exp_t;
   exp_t q1[$];
   exp_t q2[$];
   int   st1, st2;

   // dut1 signals
   logic        start1 = 1'b0;
   logic [1:0]  mode1 = '0;
   logic [31:0] n1 = '0;
   logic        idle1, done1, a_ce1, b_ce1;
   logic [31:0] ret1, a_addr1, b_addr1, a_q1, b_q1;
   logic [31:0] mem1a[16];
   logic [31:0] mem1b[16];

   // dut2 signals
   logic        start2 = 1'b0;
   logic [1:0]  mode2 = '0;
   logic [7:0]  n2 = '0;
   logic        idle2, done2, a_ce2, b_ce2;
   logic [7:0]  ret2, a_addr2, b_addr2;
   logic [7:0]  mem2a[16];
   logic [7:0]  mem2b[16];
   logic [7:0]  a_p2[3];
   logic [7:0]  b_p2[3];

   vec_reduce_engine #(.DATA_W(32), .ADDR_W(32), .MEM_LAT(1)) dut1 (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start1), .mode(mode1), .n(n1),
      .idle(idle1), .done(done1), .return_val(ret1),
      .a_address0(a_addr1), .a_ce0(a_ce1), .a_q0(a_q1),
      .b_address0(b_addr1), .b_ce0(b_ce1), .b_q0(b_q1)
   );

   vec_reduce_engine #(.DATA_W(8), .ADDR_W(8), .MEM_LAT(3)) dut2 (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start2), .mode(mode2), .n(n2),
      .idle(idle2), .done(done2), .return_val(ret2),
      .a_address0(a_addr2), .a_ce0(a_ce2), .a_q0(a_p2[2]),
      .b_address0(b_addr2), .b_ce0(b_ce2), .b_q0(b_p2[2])
   );

   // Memory models: one and three register stages of read latency.
   always @(posedge sys_clk) begin
      a_q1 <= mem1a[a_addr1[3:0]];
      b_q1 <= mem1b[b_addr1[3:0]];
      a_p2[0] <= mem2a[a_addr2[3:0]];
      b_p2[0] <= mem2b[b_addr2[3:0]];
      for (int s = 1; s < 3; s++) begin
         a_p2[s] <= a_p2[s-1];
         b_p2[s] <= b_p2[s-1];
      end
   end

   logic bce1_seen = 1'b0;
   always @(posedge sys_clk) if (b_ce1) bce1_seen <= 1'b1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitors: every done pulse must match the oldest outstanding expectation.
   always @(negedge sys_clk) begin
      exp_t e;
      if (done1) begin
         if (q1.size() == 0) chk("dut1_spurious_done", 64'd1, 64'd0);
         else begin
            e = q1.pop_front();
            chk("dut1_result", 64'(ret1), 64'(e.val));
            chk("dut1_latency", 64'(cyc - st1 + 1), 64'(e.lat));
         end
      end
      if (done2) begin
         if (q2.size() == 0) chk("dut2_spurious_done", 64'd1, 64'd0);
         else begin
            e = q2.pop_front();
            chk("dut2_result", 64'(ret2), 64'(e.val[7:0]));
            chk("dut2_latency", 64'(cyc - st2 + 1), 64'(e.lat));
         end
      end
   end

   task automatic run1(input logic [1:0] m, input logic [31:0] cnt, input logic [31:0] val,
                       input int lat);
      exp_t e;
      int   k;
      @(negedge sys_clk);
      e.val = val;
      e.lat = lat;
      q1.push_back(e);
      start1 = 1'b1; mode1 = m; n1 = cnt;
      @(posedge sys_clk);
      #1;
      st1 = cyc; start1 = 1'b0; mode1 = ~m; n1 = 32'd99;
      k = 0;
      while (q1.size() != 0 && k < 200) begin
         @(negedge sys_clk);
         k++;
      end
      if (q1.size() != 0) begin
         chk("dut1_timeout", 64'd1, 64'd0);
         q1.delete();
      end
   endtask

   task automatic run2(input logic [1:0] m, input logic [7:0] cnt, input logic [7:0] val,
                       input int lat, input int poke);
      exp_t e;
      int   k;
      @(negedge sys_clk);
      e.val = {24'd0, val};
      e.lat = lat;
      q2.push_back(e);
      start2 = 1'b1; mode2 = m; n2 = cnt;
      @(posedge sys_clk);
      #1;
      st2 = cyc; start2 = 1'b0; mode2 = ~m; n2 = 8'd2;
      k = 0;
      while (q2.size() != 0 && k < 200) begin
         @(negedge sys_clk);
         k++;
         start2 = (k == poke);
      end
      start2 = 1'b0;
      if (q2.size() != 0) begin
         chk("dut2_timeout", 64'd1, 64'd0);
         q2.delete();
      end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         mem1a[i] = 32'd0; mem1b[i] = 32'd0; mem2a[i] = 8'd0; mem2b[i] = 8'd0;
      end
      #12;
      chk("rst_idle1", 64'(idle1), 64'd1);
      chk("rst_done1", 64'(done1), 64'd0);
      chk("rst_ret1", 64'(ret1), 64'd0);
      chk("rst_ce1", 64'({a_ce1, b_ce1}), 64'd0);
      chk("rst_addr1", 64'({a_addr1, b_addr1}), 64'd0);
      chk("rst_idle2", 64'(idle2), 64'd1);
      chk("rst_ret2", 64'(ret2), 64'd0);
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      repeat (2) @(negedge sys_clk);

      // T1: sum(a) = 10, b never read
      mem1a[0] = 1; mem1a[1] = 2; mem1a[2] = 3; mem1a[3] = 4;
      bce1_seen = 1'b0;
      run1(2'b00, 32'd4, 32'd10, 6);
      chk("t1_b_ce0_quiet", 64'(bce1_seen), 64'd0);
      chk("t1_idle_after", 64'(idle1), 64'd1);

      // T2: dot = 2*5 + 3*6 + 4*7 = 56, result held afterwards
      mem1a[0] = 2; mem1a[1] = 3; mem1a[2] = 4;
      mem1b[0] = 5; mem1b[1] = 6; mem1b[2] = 7;
      run1(2'b10, 32'd3, 32'd56, 5);
      chk("t2_b_ce0_used", 64'(bce1_seen), 64'd1);
      repeat (3) @(negedge sys_clk);
      chk("t2_hold", 64'(ret1), 64'd56);

      // T4: signed max of {-5,-2,-9} = -2; n=0 in max mode gives 0 in cycle 1
      mem1a[0] = -32'sd5; mem1a[1] = -32'sd2; mem1a[2] = -32'sd9;
      run1(2'b11, 32'd3, 32'hFFFF_FFFE, 5);
      run1(2'b11, 32'd0, 32'd0, 1);
      // sum(a+b) with full width on dut1
      mem1a[0] = 32'hFFFF_FFFF; mem1a[1] = 3; mem1b[0] = 2; mem1b[1] = 4;
      run1(2'b01, 32'd2, 32'd8, 4);

      // T3: 8-bit wrap, (200+0)+(100+0) = 300 mod 256 = 44
      mem2a[0] = 8'd200; mem2a[1] = 8'd100; mem2b[0] = 8'd0; mem2b[1] = 8'd0;
      run2(2'b01, 8'd2, 8'd44, 6, 0);
      // T5: latency 3, five ones, start poked mid-run must be ignored
      for (int i = 0; i < 5; i++) mem2a[i] = 8'd1;
      run2(2'b00, 8'd5, 8'd5, 9, 3);
      // 8-bit dot wrap: 16*16 + 3*5 = 271 mod 256 = 15
      mem2a[0] = 8'd16; mem2a[1] = 8'd3; mem2b[0] = 8'd16; mem2b[1] = 8'd5;
      run2(2'b10, 8'd2, 8'd15, 6, 0);

      // T6: reset during FETCH aborts without a done pulse
      for (int i = 0; i < 8; i++) mem1a[i] = 32'(i + 1);
      @(negedge sys_clk);
      start1 = 1'b1; mode1 = 2'b00; n1 = 32'd8;
      @(negedge sys_clk);
      start1 = 1'b0;
      @(negedge sys_clk);
      chk("t6_fetching", 64'(a_ce1), 64'd1);
      sys_rst_n = 1'b0;
      #1;
      chk("t6_idle", 64'(idle1), 64'd1);
      chk("t6_ce", 64'({a_ce1, b_ce1}), 64'd0);
      chk("t6_done", 64'(done1), 64'd0);
      chk("t6_ret_cleared", 64'(ret1), 64'd0);
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      repeat (15) @(negedge sys_clk);
      mem1a[0] = 7; mem1a[1] = 8; mem1a[2] = 9;
      run1(2'b00, 32'd3, 32'd24, 5);

      repeat (10) @(negedge sys_clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
